// File: rtl/ctr_pkg.sv
// Shared types and constants for the up/down modulo counter family.
package ctr_pkg;

   typedef enum logic [1:0] {
      CTR_WRAP    = 2'b00,
      CTR_SAT     = 2'b01,
      CTR_ONESHOT = 2'b10,
      CTR_RSVD    = 2'b11
   } ctr_mode_e;

   localparam int PRESCALE_MAX   = 256;
   localparam int PRESCALE_CNT_W = $clog2(PRESCALE_MAX);

endpackage

// File: rtl/ctr_if.sv
// Signal bundle carrying every port of mod_updown_ctr, for bench-side wiring.
interface ctr_if #(parameter int W = 4);
   logic         clk;
   logic         reset_n;
   logic         clr;
   logic         en;
   logic         up_dn;
   logic         load;
   logic [W-1:0] load_val;
   logic [1:0]   mode;
   logic [W-1:0] count;
   logic         tc;
   logic         done;
   logic         load_err;
endinterface

// File: rtl/ctr_prescaler.sv
// Divides enabled cycles by PRESCALE; tick marks the last enabled cycle of each group.
module ctr_prescaler
   import ctr_pkg::*;
#(
   parameter int PRESCALE = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam logic [PRESCALE_CNT_W-1:0] LAST = PRESCALE_CNT_W'(PRESCALE - 1);

   logic [PRESCALE_CNT_W-1:0] cnt;

   assign tick = en && (cnt == LAST);

   // Only enabled cycles advance the divider, so a paused count keeps its phase.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mod_updown_ctr.sv
// Modulo up/down counter with wrap, saturate and one-shot terminal behaviour.
module mod_updown_ctr
   import ctr_pkg::*;
#(
   parameter int W        = 4,
   parameter int MOD      = 2 ** W,
   parameter int PRESCALE = 1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         clr,
   input  logic         en,
   input  logic         up_dn,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic [1:0]   mode,
   output logic [W-1:0] count,
   output logic         tc,
   output logic         done,
   output logic         load_err
);

   // One extra bit keeps the range check exact when MOD equals 2**W.
   localparam logic [W-1:0] MAX_VAL = W'(MOD - 1);
   localparam logic [W:0]   MOD_EXT = (W + 1)'(MOD);

   ctr_mode_e mode_e;
   logic      tick;
   logic      step;
   logic      at_term;
   logic      sat_hit;

   assign mode_e  = ctr_mode_e'(mode);
   assign step    = en && tick && !done;
   assign at_term = up_dn ? (count == MAX_VAL) : (count == '0);

   generate
      if (PRESCALE > 1) begin : g_pre
         ctr_prescaler #(.PRESCALE(PRESCALE)) u_pre (
            .clk     (clk),
            .reset_n (reset_n),
            .clr     (clr | load),
            .en      (en),
            .tick    (tick)
         );
      end else begin : g_nopre
         assign tick = 1'b1;
      end
   endgenerate

   // sat_hit remembers that the current saturated hold already produced its tc.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count    <= '0;
         tc       <= 1'b0;
         done     <= 1'b0;
         load_err <= 1'b0;
         sat_hit  <= 1'b0;
      end else begin
         tc       <= 1'b0;
         load_err <= 1'b0;
         if (clr) begin
            count   <= '0;
            done    <= 1'b0;
            sat_hit <= 1'b0;
         end else if (load) begin
            if ({1'b0, load_val} < MOD_EXT) begin
               count <= load_val;
            end else begin
               count    <= MAX_VAL;
               load_err <= 1'b1;
            end
            done    <= 1'b0;
            sat_hit <= 1'b0;
         end else begin
            if (done && mode_e != CTR_ONESHOT) begin
               done <= 1'b0;
            end
            if (step) begin
               if (!at_term) begin
                  count   <= up_dn ? count + 1'b1 : count - 1'b1;
                  sat_hit <= 1'b0;
               end else begin
                  case (mode_e)
                     CTR_SAT: begin
                        if (!sat_hit) begin
                           tc <= 1'b1;
                        end
                        sat_hit <= 1'b1;
                     end
                     CTR_ONESHOT: begin
                        done <= 1'b1;
                        tc   <= 1'b1;
                     end
                     default: begin
                        count <= up_dn ? '0 : MAX_VAL;
                        tc    <= 1'b1;
                     end
                  endcase
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_mod_updown_ctr.sv
// Directed self-checking bench: MOD=10 counter without prescaler, and with PRESCALE=3.
module tb_mod_updown_ctr;
   import ctr_pkg::*;

   logic clk = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   ctr_if #(.W(4)) if_a ();
   ctr_if #(.W(4)) if_b ();

   assign if_a.clk = clk;
   assign if_b.clk = clk;

   mod_updown_ctr #(.W(4), .MOD(10), .PRESCALE(1)) dut_a (
      .clk      (if_a.clk),
      .reset_n  (if_a.reset_n),
      .clr      (if_a.clr),
      .en       (if_a.en),
      .up_dn    (if_a.up_dn),
      .load     (if_a.load),
      .load_val (if_a.load_val),
      .mode     (if_a.mode),
      .count    (if_a.count),
      .tc       (if_a.tc),
      .done     (if_a.done),
      .load_err (if_a.load_err)
   );

   mod_updown_ctr #(.W(4), .MOD(10), .PRESCALE(3)) dut_b (
      .clk      (if_b.clk),
      .reset_n  (if_b.reset_n),
      .clr      (if_b.clr),
      .en       (if_b.en),
      .up_dn    (if_b.up_dn),
      .load     (if_b.load),
      .load_val (if_b.load_val),
      .mode     (if_b.mode),
      .count    (if_b.count),
      .tc       (if_b.tc),
      .done     (if_b.done),
      .load_err (if_b.load_err)
   );

   // Advance one clock and land just after the edge, where inputs change and outputs are sampled.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      if_a.reset_n = 1'b0; if_a.clr = 1'b0; if_a.en = 1'b0; if_a.up_dn = 1'b1;
      if_a.load = 1'b0; if_a.load_val = '0; if_a.mode = 2'b00;
      if_b.reset_n = 1'b0; if_b.clr = 1'b0; if_b.en = 1'b0; if_b.up_dn = 1'b1;
      if_b.load = 1'b0; if_b.load_val = '0; if_b.mode = 2'b00;
      #12;
      checks++;
      if ({if_a.count, if_a.tc, if_a.done, if_a.load_err} !== 7'b0) begin
         failures++;
         $display("[TB] FAIL reset_a: got count=%0d tc=%b done=%b load_err=%b, expected all 0",
                  if_a.count, if_a.tc, if_a.done, if_a.load_err);
      end
      checks++;
      if ({if_b.count, if_b.tc, if_b.done, if_b.load_err} !== 7'b0) begin
         failures++;
         $display("[TB] FAIL reset_b: got count=%0d tc=%b done=%b load_err=%b, expected all 0",
                  if_b.count, if_b.tc, if_b.done, if_b.load_err);
      end
      cyc();
      if_a.reset_n = 1'b1;
      if_b.reset_n = 1'b1;
      cyc();
   endtask

   task automatic test_wrap_up();
      int exp_cnt [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
      bit exp_tc  [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
      if_a.mode = 2'b00; if_a.up_dn = 1'b1; if_a.en = 1'b1;
      for (int i = 0; i < 12; i++) begin
         cyc();
         checks++;
         if (if_a.count !== 4'(exp_cnt[i]) || if_a.tc !== exp_tc[i]) begin
            failures++;
            $display("[TB] FAIL wrap_up step %0d: got count=%0d tc=%b, expected count=%0d tc=%b",
                     i + 1, if_a.count, if_a.tc, exp_cnt[i], exp_tc[i]);
         end
      end
      if_a.en = 1'b0;
      cyc();
      checks++;
      if (if_a.count !== 4'd2 || if_a.tc !== 1'b0) begin
         failures++;
         $display("[TB] FAIL wrap_up_hold: got count=%0d tc=%b, expected count=2 tc=0",
                  if_a.count, if_a.tc);
      end
   endtask

   task automatic test_wrap_down();
      int exp_cnt [4] = '{1, 0, 9, 8};
      bit exp_tc  [4] = '{0, 0, 1, 0};
      if_a.mode = 2'b00; if_a.up_dn = 1'b0; if_a.load = 1'b1; if_a.load_val = 4'd2;
      cyc();
      if_a.load = 1'b0;
      checks++;
      if (if_a.count !== 4'd2 || if_a.tc !== 1'b0 || if_a.load_err !== 1'b0) begin
         failures++;
         $display("[TB] FAIL down_load: got count=%0d tc=%b load_err=%b, expected count=2 tc=0 load_err=0",
                  if_a.count, if_a.tc, if_a.load_err);
      end
      if_a.en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         checks++;
         if (if_a.count !== 4'(exp_cnt[i]) || if_a.tc !== exp_tc[i]) begin
            failures++;
            $display("[TB] FAIL wrap_down step %0d: got count=%0d tc=%b, expected count=%0d tc=%b",
                     i + 1, if_a.count, if_a.tc, exp_cnt[i], exp_tc[i]);
         end
      end
      if_a.en = 1'b0;
   endtask

   task automatic test_saturate();
      int exp_cnt [5] = '{8, 9, 9, 9, 9};
      bit exp_tc  [5] = '{0, 0, 1, 0, 0};
      int tc_pulses = 0;
      if_a.mode = 2'b01; if_a.up_dn = 1'b1; if_a.load = 1'b1; if_a.load_val = 4'd7;
      cyc();
      if_a.load = 1'b0; if_a.en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         if (if_a.tc === 1'b1) tc_pulses++;
         checks++;
         if (if_a.count !== 4'(exp_cnt[i]) || if_a.tc !== exp_tc[i]) begin
            failures++;
            $display("[TB] FAIL saturate step %0d: got count=%0d tc=%b, expected count=%0d tc=%b",
                     i + 1, if_a.count, if_a.tc, exp_cnt[i], exp_tc[i]);
         end
      end
      checks++;
      if (tc_pulses != 1) begin
         failures++;
         $display("[TB] FAIL saturate_tc_count: got %0d pulses, expected 1", tc_pulses);
      end
      if_a.up_dn = 1'b0;
      cyc();
      checks++;
      if (if_a.count !== 4'd8 || if_a.tc !== 1'b0) begin
         failures++;
         $display("[TB] FAIL saturate_reverse: got count=%0d tc=%b, expected count=8 tc=0",
                  if_a.count, if_a.tc);
      end
      if_a.en = 1'b0;
   endtask

   task automatic test_oneshot();
      int exp_cnt [4] = '{9, 9, 9, 9};
      bit exp_tc  [4] = '{0, 1, 0, 0};
      bit exp_dn  [4] = '{0, 1, 1, 1};
      if_a.mode = 2'b10; if_a.up_dn = 1'b1; if_a.load = 1'b1; if_a.load_val = 4'd8;
      cyc();
      if_a.load = 1'b0; if_a.en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         checks++;
         if (if_a.count !== 4'(exp_cnt[i]) || if_a.tc !== exp_tc[i] || if_a.done !== exp_dn[i]) begin
            failures++;
            $display("[TB] FAIL oneshot step %0d: got count=%0d tc=%b done=%b, expected count=%0d tc=%b done=%b",
                     i + 1, if_a.count, if_a.tc, if_a.done, exp_cnt[i], exp_tc[i], exp_dn[i]);
         end
      end
      if_a.en = 1'b0; if_a.load = 1'b1; if_a.load_val = 4'd3;
      cyc();
      if_a.load = 1'b0;
      checks++;
      if (if_a.count !== 4'd3 || if_a.done !== 1'b0) begin
         failures++;
         $display("[TB] FAIL oneshot_reload: got count=%0d done=%b, expected count=3 done=0",
                  if_a.count, if_a.done);
      end
      if_a.load = 1'b1; if_a.load_val = 4'd9;
      cyc();
      if_a.load = 1'b0; if_a.en = 1'b1;
      cyc();
      if_a.en = 1'b0;
      checks++;
      if (if_a.done !== 1'b1 || if_a.tc !== 1'b1) begin
         failures++;
         $display("[TB] FAIL oneshot_from_9: got done=%b tc=%b, expected done=1 tc=1", if_a.done, if_a.tc);
      end
      if_a.mode = 2'b00;
      cyc();
      checks++;
      if (if_a.done !== 1'b0 || if_a.count !== 4'd9) begin
         failures++;
         $display("[TB] FAIL oneshot_mode_exit: got done=%b count=%0d, expected done=0 count=9",
                  if_a.done, if_a.count);
      end
   endtask

   task automatic test_load_clamp();
      if_a.mode = 2'b00; if_a.en = 1'b0; if_a.load = 1'b1; if_a.load_val = 4'd12;
      cyc();
      if_a.load = 1'b0;
      checks++;
      if (if_a.count !== 4'd9 || if_a.load_err !== 1'b1) begin
         failures++;
         $display("[TB] FAIL clamp_load: got count=%0d load_err=%b, expected count=9 load_err=1",
                  if_a.count, if_a.load_err);
      end
      cyc();
      checks++;
      if (if_a.count !== 4'd9 || if_a.load_err !== 1'b0) begin
         failures++;
         $display("[TB] FAIL clamp_pulse: got count=%0d load_err=%b, expected count=9 load_err=0",
                  if_a.count, if_a.load_err);
      end
      if_a.clr = 1'b1; if_a.load = 1'b1; if_a.load_val = 4'd5;
      cyc();
      if_a.clr = 1'b0; if_a.load = 1'b0;
      checks++;
      if (if_a.count !== 4'd0 || if_a.load_err !== 1'b0 || if_a.tc !== 1'b0) begin
         failures++;
         $display("[TB] FAIL clr_over_load: got count=%0d load_err=%b tc=%b, expected count=0 load_err=0 tc=0",
                  if_a.count, if_a.load_err, if_a.tc);
      end
   endtask

   task automatic test_prescale();
      bit en_pat  [8] = '{1, 1, 1, 0, 1, 1, 0, 1};
      int exp_cnt [8] = '{0, 0, 1, 1, 1, 1, 1, 2};
      if_b.mode = 2'b00; if_b.up_dn = 1'b1; if_b.clr = 1'b1;
      cyc();
      if_b.clr = 1'b0; if_b.en = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         cyc();
         checks++;
         if (if_b.count !== 4'(k / 3) || if_b.tc !== 1'b0) begin
            failures++;
            $display("[TB] FAIL prescale_run cycle %0d: got count=%0d tc=%b, expected count=%0d tc=0",
                     k, if_b.count, if_b.tc, k / 3);
         end
      end
      if_b.en = 1'b1; cyc();
      if_b.en = 1'b0; cyc();
      if_b.en = 1'b1; cyc();
      checks++;
      if (if_b.count !== 4'd5) begin
         failures++;
         $display("[TB] FAIL prescale_pre_reset: got count=%0d, expected 5", if_b.count);
      end
      #2;
      if_b.reset_n = 1'b0;
      #1;
      checks++;
      if (if_b.count !== 4'd0 || if_b.tc !== 1'b0) begin
         failures++;
         $display("[TB] FAIL async_reset: got count=%0d tc=%b, expected count=0 tc=0", if_b.count, if_b.tc);
      end
      cyc();
      if_b.reset_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if_b.en = en_pat[i];
         cyc();
         checks++;
         if (if_b.count !== 4'(exp_cnt[i]) || if_b.tc !== 1'b0) begin
            failures++;
            $display("[TB] FAIL prescale_after_reset cycle %0d: got count=%0d tc=%b, expected count=%0d tc=0",
                     i + 1, if_b.count, if_b.tc, exp_cnt[i]);
         end
      end
      if_b.en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_wrap_up();
      test_wrap_down();
      test_saturate();
      test_oneshot();
      test_load_clamp();
      test_prescale();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mod_updown_ctr.md
MOD_UPDOWN_CTR -- requirements
Module: mod_updown_ctr

Interface
REQ-001 Parameter W, default 4, counter width in bits.
REQ-002 Parameter MOD, default 2**W, modulus; count range 0..MOD-1; legal 2 <= MOD <= 2**W.
REQ-003 Parameter PRESCALE, default 1, clocks per count step; legal 1..256.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 clr  input  1  synchronous clear to 0.
REQ-007 en  input  1  count enable.
REQ-008 up_dn  input  1  direction: 1 = up, 0 = down.
REQ-009 load  input  1  synchronous load of load_val.
REQ-010 load_val  input  W  value to load.
REQ-011 mode  input  2  00 wrap, 01 saturate, 10 one-shot, 11 reserved (behaves as wrap).
REQ-012 count  output  W  current count, registered.
REQ-013 tc  output  1  one-cycle pulse, terminal-count step taken.
REQ-014 done  output  1  one-shot finished, level.
REQ-015 load_err  output  1  one-cycle pulse, out-of-range load clamped.

Function
REQ-016 Step qualifier: step = en & tick & ~done; tick from prescaler, asserted every PRESCALE-th enabled cycle (always 1 when PRESCALE=1).
REQ-017 Prescaler advances only while en=1; holds value when en=0; cleared by clr, load, reset.
REQ-018 Priority per cycle: clr > load > step > hold.
REQ-019 clr: count<=0, done<=0, prescaler<=0; no tc.
REQ-020 load: count<=load_val if load_val<MOD, else count<=MOD-1 and load_err=1 next cycle; done<=0; no tc.
REQ-021 Terminal value: MOD-1 when up_dn=1, 0 when up_dn=0.
REQ-022 Step at non-terminal value: count +1 (up) or -1 (down), no tc.
REQ-023 Step at terminal, wrap: count<=0 (up) or MOD-1 (down); tc=1 next cycle.
REQ-024 Step at terminal, saturate: count holds; tc=1 only on first step reaching terminal hold, i.e. tc asserts once per arrival, not every held cycle.
REQ-025 Step at terminal, one-shot: count holds; done<=1; tc=1 once.
REQ-026 done clears only on clr, load, reset or mode change away from one-shot.
REQ-027 up_dn or mode change takes effect on the next step; no glitch on count.
REQ-028 All outputs registered; count updates 1 cycle after qualifying edge.
REQ-029 Arithmetic in W bits; MOD-1 compare must not overflow when MOD=2**W.

Reset
REQ-030 reset_n=0 asynchronously forces count=0, tc=0, done=0, load_err=0, prescaler=0.
REQ-031 Deassertion synchronous to clk externally; first step no earlier than first edge after release.
REQ-032 Reset mid-count or mid-prescale discards all progress; no tc emitted.

Structure
REQ-033 Shared package ctr_pkg holds mode enum (CTR_WRAP, CTR_SAT, CTR_ONESHOT, CTR_RSVD) and prescaler max constant.
REQ-034 One sub-module ctr_prescaler generates tick; instantiated only when PRESCALE>1, else tick tied high.
REQ-035 Interface bundle ctr_if parametrised by W carries all ports for bench connection.

Verification
REQ-036 W=4, MOD=10, wrap, up, en=1 for 12 steps from 0 -> count 0..9,0,1; tc high exactly the cycle after 9->0.
REQ-037 MOD=10, wrap, down, load 2 then step 4 -> count 2,1,0,9,8; tc after 0->9.
REQ-038 MOD=10, saturate, up from 7, 5 steps -> 8,9,9,9,9; single tc pulse.
REQ-039 MOD=10, one-shot, up from 8 -> 9 then hold, done=1; further en ignored; load 3 -> count 3, done=0.
REQ-040 Load 12 with MOD=10 -> count 9, load_err pulse 1 cycle; clr and load same cycle -> count 0.
REQ-041 PRESCALE=3, en toggled, reset_n pulsed low mid-count at count 5 -> count 0 immediately, steps every 3rd enabled cycle after release.
